intc_vec: RTL and testbench

Parametrised vectored interrupt controller; the next generation of the fixed 4-input intc used in the SoC.
- Takes N_IRQ source lines (accelerator done flags, GPIO events) and latches them into pending bits.
- Resolves fixed priority, lowest index highest.
- Drives IRQ/IACK/ADDR to the mips core.
- Memory-mapped on the same 2-bit word-address peripheral bus as fact_top/gpio_top, selected via the address decoder.
- Adds what the old block lacks: per-source enable mask, software W1C of pending bits, status readback, explicit end-of-interrupt (EOI).

---
 rtl/intc_vec_if.sv | 13 +
 rtl/intc_vec.sv | 110 +++++++++++
 tb/tb_intc_vec.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/intc_vec_if.sv
// Peripheral-bus and CPU interrupt handshake bundle for intc_vec.
interface intc_vec_if;
    logic [1:0]  A;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;
    logic        IACK;
    logic [31:0] ADDR;

    modport master (output A, WE, WD, IACK, input RD, IRQ, ADDR);
    modport slave  (input A, WE, WD, IACK, output RD, IRQ, ADDR);
endinterface

// File: rtl/intc_vec.sv
// Vectored interrupt controller: pending/enable/status/EOI registers, fixed priority (lowest index wins).
// Define INTC_VEC_EDGE_EN for rising-edge source detection; default is level mode.
module intc_vec #(
    parameter int          N_IRQ      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] src,
    intc_vec_if.slave        bus
);
    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state, state_n;
    logic [N_IRQ-1:0] pending, pending_n, en, en_n, events, w1c, ack_clr, active;
    logic [ID_W-1:0]  id, id_n, win;
    logic             irq;
    logic             wr_pend, wr_en, wr_eoi, ack;

    assign wr_pend = bus.WE && (bus.A == 2'd0);
    assign wr_en   = bus.WE && (bus.A == 2'd1);
    assign wr_eoi  = bus.WE && (bus.A == 2'd3);
    assign ack     = (state == REQ) && bus.IACK;

`ifdef INTC_VEC_EDGE_EN
    logic [N_IRQ-1:0] src_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) src_q <= '0;
        else      src_q <= src;
    end
    assign events = src & ~src_q;
`else
    assign events = src;
`endif

    // Set has priority over both W1C and acknowledge clears.
    always_comb begin
        w1c       = wr_pend ? bus.WD[N_IRQ-1:0] : '0;
        ack_clr   = '0;
        if (ack) ack_clr[id] = 1'b1;
        pending_n = (pending & ~(w1c | ack_clr)) | events;
        en_n      = wr_en ? bus.WD[N_IRQ-1:0] : en;
    end

    assign active = pending & en;

    always_comb begin
        win = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (active[i]) win = ID_W'(i);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            en      <= '0;
        end else begin
            pending <= pending_n;
            en      <= en_n;
        end
    end

    // Withdrawal looks at next-cycle pending/enable so a W1C or mask write drops the request at once.
    always_comb begin
        state_n = state;
        id_n    = id;
        case (state)
            IDLE:    if (|active) begin
                         state_n = REQ;
                         id_n    = win;
                     end
            REQ:     if (ack)                               state_n = SERVICE;
                     else if (!(pending_n[id] && en_n[id])) state_n = IDLE;
            SERVICE: if (wr_eoi)                            state_n = IDLE;
            default:                                        state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            id    <= '0;
            irq   <= 1'b0;
        end else begin
            state <= state_n;
            id    <= id_n;
            irq   <= (state_n == REQ);
        end
    end

    assign bus.IRQ  = irq;
    assign bus.ADDR = VEC_BASE + VEC_STRIDE * 32'(id);

    always_comb begin
        bus.RD = '0;
        case (bus.A)
            2'd0: bus.RD = 32'(pending);
            2'd1: bus.RD = 32'(en);
            2'd2: begin
                bus.RD[31]       = (state == SERVICE);
                bus.RD[30]       = (state == REQ);
                bus.RD[ID_W-1:0] = id;
            end
            default: bus.RD = '0;
        endcase
    end
endmodule

// File: tb/tb_intc_vec.sv
// Directed table-driven bench for intc_vec (4-source instance) plus a 32-source instance.
module tb_intc_vec;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  src;
    logic [31:0] src32;
    int          total = 0;
    int          bad = 0;

    intc_vec_if bus();
    intc_vec_if bus32();

    intc_vec #(.N_IRQ(4)) dut (
        .clk(clk), .rst(rst_n), .src(src), .bus(bus.slave)
    );
    intc_vec #(.N_IRQ(32)) dut32 (
        .clk(clk), .rst(rst_n), .src(src32), .bus(bus32.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  src;
        logic [1:0]  a;
        logic        we;
        logic [31:0] wd;
        logic        iack;
        logic        irq;
        logic [31:0] addr;
        logic [31:0] rd;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic [3:0] s, input logic [1:0] a, input logic we,
                       input logic [31:0] wd, input logic iack,
                       input logic irq, input logic [31:0] addr, input logic [31:0] rd);
        vec_t v;
        v.src = s; v.a = a; v.we = we; v.wd = wd; v.iack = iack;
        v.irq = irq; v.addr = addr; v.rd = rd;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, then sample just after the following rising edge.
    task automatic drive(input logic [3:0] s, input logic [1:0] a, input logic we,
                         input logic [31:0] wd, input logic iack);
        @(negedge clk);
        src = s; bus.A = a; bus.WE = we; bus.WD = wd; bus.IACK = iack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        src = '0; src32 = '0;
        bus.A = '0; bus.WE = 1'b0; bus.WD = '0; bus.IACK = 1'b0;
        bus32.A = '0; bus32.WE = 1'b0; bus32.WD = '0; bus32.IACK = 1'b0;

        //   src  A   WE  WD          IACK  IRQ  ADDR          RD
        add(4'h0, 0, 1, 32'hF,        0,    0,   32'h100, 32'h0000_000F); // 0: EN=F (RD shows A=0 pend... see below)
        tv[0].a = 2'd1;
        add(4'h4, 0, 0, 0,            0,    0,   32'h100, 32'h0000_0004);
        add(4'h0, 2, 0, 0,            0,    1,   32'h120, 32'h4000_0002);
        add(4'h0, 0, 0, 0,            1,    0,   32'h120, 32'h0000_0000);
        add(4'h0, 2, 0, 0,            0,    0,   32'h120, 32'h8000_0002);
        add(4'h0, 3, 1, 0,            0,    0,   32'h120, 32'h0000_0000);
        add(4'hA, 0, 0, 0,            0,    0,   32'h120, 32'h0000_000A);
        add(4'h0, 2, 0, 0,            0,    1,   32'h110, 32'h4000_0001);
        add(4'h0, 0, 0, 0,            1,    0,   32'h110, 32'h0000_0008);
        add(4'h0, 3, 1, 0,            0,    0,   32'h110, 32'h0000_0000);
        add(4'h0, 2, 0, 0,            0,    1,   32'h130, 32'h4000_0003);
        add(4'h0, 0, 0, 0,            0,    1,   32'h130, 32'h0000_0008);
        add(4'h0, 2, 0, 0,            1,    0,   32'h130, 32'h8000_0003);
        add(4'h0, 3, 1, 0,            0,    0,   32'h130, 32'h0000_0000);
        add(4'h0, 1, 1, 32'h0,        0,    0,   32'h130, 32'h0000_0000);
        add(4'h1, 0, 0, 0,            0,    0,   32'h130, 32'h0000_0001);
        add(4'h0, 2, 0, 0,            0,    0,   32'h130, 32'h0000_0003);
        add(4'h0, 1, 1, 32'h1,        0,    0,   32'h130, 32'h0000_0001);
        add(4'h0, 2, 0, 0,            0,    1,   32'h100, 32'h4000_0000);
        add(4'h0, 0, 1, 32'h1,        0,    0,   32'h100, 32'h0000_0000);
        add(4'h0, 2, 0, 0,            0,    0,   32'h100, 32'h0000_0000);
        add(4'h1, 0, 0, 0,            0,    0,   32'h100, 32'h0000_0001);
        add(4'h0, 2, 0, 0,            0,    1,   32'h100, 32'h4000_0000);
        add(4'h0, 0, 0, 0,            1,    0,   32'h100, 32'h0000_0000);
        add(4'h1, 0, 0, 0,            0,    0,   32'h100, 32'h0000_0001);
        add(4'h0, 2, 0, 0,            0,    0,   32'h100, 32'h8000_0000);
        add(4'h0, 0, 0, 0,            1,    0,   32'h100, 32'h0000_0001);
        add(4'h0, 3, 1, 0,            0,    0,   32'h100, 32'h0000_0000);
        add(4'h0, 2, 0, 0,            0,    1,   32'h100, 32'h4000_0000);
        add(4'h0, 0, 1, 32'h1,        1,    0,   32'h100, 32'h0000_0000);
        add(4'h0, 2, 0, 0,            0,    0,   32'h100, 32'h8000_0000);
        add(4'h0, 3, 1, 0,            0,    0,   32'h100, 32'h0000_0000);
        add(4'h1, 0, 1, 32'h1,        0,    0,   32'h100, 32'h0000_0001);
        add(4'h0, 2, 0, 0,            0,    1,   32'h100, 32'h4000_0000);
        add(4'h0, 1, 1, 32'h0,        0,    0,   32'h100, 32'h0000_0000);
        add(4'h0, 0, 1, 32'hF,        0,    0,   32'h100, 32'h0000_0000);
        add(4'h0, 3, 1, 0,            0,    0,   32'h100, 32'h0000_0000);
        add(4'h0, 2, 0, 0,            0,    0,   32'h100, 32'h0000_0000);
        tv[0].rd = 32'h0000_000F;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq",  {31'b0, bus.IRQ}, 32'h0);
        chk("rst_addr", bus.ADDR, 32'h100);
        for (int k = 0; k < 3; k++) begin
            bus.A = 2'(k);
            #1;
            chk($sformatf("rst_rd%0d", k), bus.RD, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            drive(tv[i].src, tv[i].a, tv[i].we, tv[i].wd, tv[i].iack);
            chk($sformatf("v%0d_irq", i),  {31'b0, bus.IRQ}, {31'b0, tv[i].irq});
            chk($sformatf("v%0d_addr", i), bus.ADDR, tv[i].addr);
            chk($sformatf("v%0d_rd", i),   bus.RD, tv[i].rd);
        end

        // Held-high source, then W1C while still high (EN=0, FSM stays idle).
        for (int c = 0; c < 10; c++) drive(4'h2, 0, 0, 0, 0);
        chk("hold_pend", bus.RD, 32'h2);
        drive(4'h2, 0, 1, 32'h2, 0);
`ifdef INTC_VEC_EDGE_EN
        chk("hold_w1c", bus.RD, 32'h0);
        drive(4'h2, 0, 0, 0, 0);
        chk("hold_after", bus.RD, 32'h0);
`else
        chk("hold_w1c", bus.RD, 32'h2);
        drive(4'h2, 0, 0, 0, 0);
        chk("hold_after", bus.RD, 32'h2);
`endif
        drive(4'h0, 0, 1, 32'hF, 0);
        chk("hold_clr", bus.RD, 32'h0);

        // Asynchronous reset while in SERVICE.
        drive(4'h0, 1, 1, 32'hF, 0);
        drive(4'h1, 0, 0, 0, 0);
        drive(4'h0, 2, 0, 0, 0);
        chk("pre_rst_irq", {31'b0, bus.IRQ}, 32'h1);
        drive(4'h0, 2, 0, 0, 1);
        chk("pre_rst_stat", bus.RD, 32'h8000_0000);
        @(negedge clk);
        bus.IACK = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_irq",  {31'b0, bus.IRQ}, 32'h0);
        chk("mid_rst_stat", bus.RD, 32'h0);
        chk("mid_rst_addr", bus.ADDR, 32'h100);
        bus.A = 2'd1;
        #1;
        chk("mid_rst_en", bus.RD, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 32-source instance: highest index maps to the top vector.
        @(negedge clk);
        bus32.A = 2'd1; bus32.WE = 1'b1; bus32.WD = 32'hFFFF_FFFF;
        @(negedge clk);
        bus32.WE = 1'b0; bus32.A = 2'd0;
        src32 = 32'h8000_0000;
        @(posedge clk);
        #1;
        chk("n32_pend", bus32.RD, 32'h8000_0000);
        chk("n32_irq0", {31'b0, bus32.IRQ}, 32'h0);
        @(negedge clk);
        src32 = '0; bus32.A = 2'd2;
        @(posedge clk);
        #1;
        chk("n32_irq",  {31'b0, bus32.IRQ}, 32'h1);
        chk("n32_addr", bus32.ADDR, 32'h0000_02F0);
        chk("n32_stat", bus32.RD, 32'h4000_001F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
